// File: rtl/obstacle_pkg.sv
// Shared types, obstacle geometry tables and palette for the obstacle compositor.
// Geometry offsets are relative to the anchor column (minus margin) and the lane row.
package obstacle_pkg;

  typedef enum logic [1:0] {
    GS_START   = 2'b00,
    GS_PLAYING = 2'b01,
    GS_OVER    = 2'b10
  } game_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int OBS_X_MARGIN = 100;

  // Indexed by type: 0 flat, 1 tall, 2 falling triangle, 3 rising triangle.
  localparam int OBS_DX0 [4] = '{0, 0, 0, 0};
  localparam int OBS_DX1 [4] = '{159, 39, 79, 79};
  localparam int OBS_DY0 [4] = '{60, 0, 0, 0};
  localparam int OBS_DY1 [4] = '{100, 100, 79, 79};

  // Lane rows: top, middle, bottom; slot 3 is the disabled lane.
  localparam int ROW_Y [4] = '{0, 140, 379, 0};

  localparam logic [1:0] TYPE_FALL = 2'd2;
  localparam logic [1:0] TYPE_RISE = 2'd3;
  localparam logic [1:0] POS_NONE  = 2'd3;

  localparam int BARRY_ARM_W  = 10;
  localparam int BARRY_HEAD_H = 15;
  localparam int BARRY_PACK_H = 45;

  localparam rgb_t COL_ORANGE   = 24'hFF8000;
  localparam rgb_t COL_YELLOW   = 24'hFFFF00;
  localparam rgb_t COL_HEAD     = 24'hA4674A;
  localparam rgb_t COL_TORSO    = 24'h0A0A80;
  localparam rgb_t COL_JETPACK  = 24'h141414;
  localparam rgb_t COL_BG_START = 24'h00FF00;
  localparam rgb_t COL_BG_PLAY  = 24'hF0F0F0;
  localparam rgb_t COL_BG_OVER  = 24'h0000FF;

endpackage

// File: rtl/obstacle_shape.sv
// One obstacle channel: registers its bounds alongside the stage-1 pixel and
// evaluates the inside test combinationally against that pixel.
module obstacle_shape
  import obstacle_pkg::*;
#(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_en,
  input  logic [1:0]     i_type,
  input  logic [1:0]     i_pos,
  input  logic [X_W-1:0] i_obs_x,
  input  logic [X_W-1:0] i_x,
  input  logic [Y_W-1:0] i_y,
  output logic           o_inside
);

  localparam int SW = X_W + 1;
  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 3;

  logic signed [SW-1:0] w_base, w_ox0, w_ox1, w_oy0, w_oy1;
  logic signed [SW-1:0] r_ox0, r_ox0c, r_ox1, r_oy0, r_oy1;
  logic                 r_en, r_off;
  logic [1:0]           r_type;

  always_comb begin
    w_base = $signed(SW'(i_obs_x)) - SW'(OBS_X_MARGIN);
    w_ox0  = w_base + SW'(OBS_DX0[i_type]);
    w_ox1  = w_base + SW'(OBS_DX1[i_type]);
    w_oy0  = SW'(ROW_Y[i_pos]) + SW'(OBS_DY0[i_type]);
    w_oy1  = SW'(ROW_Y[i_pos]) + SW'(OBS_DY1[i_type]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_off  <= 1'b1;
      r_type <= '0;
      r_ox0  <= '0;
      r_ox0c <= '0;
      r_ox1  <= '0;
      r_oy0  <= '0;
      r_oy1  <= '0;
    end else begin
      r_en   <= i_en & (i_pos != POS_NONE);
      r_off  <= w_ox1[SW-1];
      r_type <= i_type;
      r_ox0  <= w_ox0;
      r_ox0c <= w_ox0[SW-1] ? '0 : w_ox0;
      r_ox1  <= w_ox1;
      r_oy0  <= w_oy0;
      r_oy1  <= w_oy1;
    end
  end

  logic signed [CW-1:0] w_cx, w_cy, w_dx, w_dy;
  logic                 w_rect;

  // Triangle tests use the unclipped left edge so the slope stays anchored.
  always_comb begin
    w_cx   = $signed(CW'(i_x));
    w_cy   = $signed(CW'(i_y));
    w_dx   = w_cx - CW'(r_ox0);
    w_dy   = w_cy - CW'(r_oy0);
    w_rect = r_en & ~r_off
           & (w_cx >= CW'(r_ox0c)) & (w_cx <= CW'(r_ox1))
           & (w_cy >= CW'(r_oy0))  & (w_cy <= CW'(r_oy1));
    case (r_type)
      TYPE_FALL: o_inside = w_rect & (w_dy <= w_dx);
      TYPE_RISE: o_inside = w_rect & ((w_cy + w_dx) >= CW'(r_oy1));
      default:   o_inside = w_rect;
    endcase
  end

endmodule

// File: rtl/obstacle_compositor.sv
// Two-stage pixel compositor with Barry/obstacle collision and game FSM.
// in_valid qualifies x/y each cycle; there is no backpressure, the pipe always advances.
module obstacle_compositor
  import obstacle_pkg::*;
#(
  parameter int N_OBS = 4,
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  parameter int C_W   = 8,
  localparam int HW   = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [X_W-1:0]       x,
  input  logic [Y_W-1:0]       y,
  input  logic [X_W-1:0]       barry_x0,
  input  logic [X_W-1:0]       barry_x1,
  input  logic [Y_W-1:0]       barry_y0,
  input  logic [Y_W-1:0]       barry_y1,
  input  logic                 on,
  input  logic                 restart,
  input  logic [N_OBS-1:0]     obs_en,
  input  logic [2*N_OBS-1:0]   obs_type,
  input  logic [2*N_OBS-1:0]   obs_pos,
  input  logic [N_OBS*X_W-1:0] obs_x,
  input  logic [N_OBS-1:0]     flick,
  output logic                 out_valid,
  output logic [C_W-1:0]       r,
  output logic [C_W-1:0]       g,
  output logic [C_W-1:0]       b,
  output logic [1:0]           game_state,
  output logic                 game_over,
  output logic [HW-1:0]        hit_idx
);

  localparam int CW = ((X_W > Y_W) ? X_W : Y_W) + 3;

  // Stage 1: pixel, Barry box, thrust and flick latched together.
  logic             r_s1_valid, r_s1_on;
  logic [X_W-1:0]   r_s1_x, r_s1_bx0, r_s1_bx1;
  logic [Y_W-1:0]   r_s1_y, r_s1_by0, r_s1_by1;
  logic [N_OBS-1:0] r_s1_flick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_on    <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_bx0   <= '0;
      r_s1_bx1   <= '0;
      r_s1_by0   <= '0;
      r_s1_by1   <= '0;
      r_s1_flick <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_on    <= on;
      r_s1_x     <= x;
      r_s1_y     <= y;
      r_s1_bx0   <= barry_x0;
      r_s1_bx1   <= barry_x1;
      r_s1_by0   <= barry_y0;
      r_s1_by1   <= barry_y1;
      r_s1_flick <= flick;
    end
  end

  logic [N_OBS-1:0] w_inside;

  for (genvar gi = 0; gi < N_OBS; gi++) begin : g_obs
    obstacle_shape #(.X_W(X_W), .Y_W(Y_W)) u_shape (
      .clk      (clk),
      .reset    (reset),
      .i_en     (obs_en[gi]),
      .i_type   (obs_type[2*gi +: 2]),
      .i_pos    (obs_pos[2*gi +: 2]),
      .i_obs_x  (obs_x[X_W*gi +: X_W]),
      .i_x      (r_s1_x),
      .i_y      (r_s1_y),
      .o_inside (w_inside[gi])
    );
  end

  logic signed [CW-1:0] w_cx, w_cy, w_bx0, w_bx1, w_by0, w_by1;
  logic                 w_jet, w_head, w_torso, w_fire, w_in_barry;

  always_comb begin
    w_cx    = $signed(CW'(r_s1_x));
    w_cy    = $signed(CW'(r_s1_y));
    w_bx0   = $signed(CW'(r_s1_bx0));
    w_bx1   = $signed(CW'(r_s1_bx1));
    w_by0   = $signed(CW'(r_s1_by0));
    w_by1   = $signed(CW'(r_s1_by1));
    w_jet   = (w_cx >= w_bx0) && (w_cx <= w_bx0 + CW'(BARRY_ARM_W))
           && (w_cy >= w_by0 + CW'(BARRY_HEAD_H)) && (w_cy <= w_by0 + CW'(BARRY_PACK_H));
    w_head  = (w_cx >= w_bx0 + CW'(BARRY_ARM_W)) && (w_cx <= w_bx1)
           && (w_cy >= w_by0) && (w_cy < w_by0 + CW'(BARRY_HEAD_H));
    w_torso = (w_cx >= w_bx0 + CW'(BARRY_ARM_W)) && (w_cx <= w_bx1)
           && (w_cy >= w_by0 + CW'(BARRY_HEAD_H)) && (w_cy <= w_by1);
    w_fire  = r_s1_on && (w_cx >= w_bx0) && (w_cx <= w_bx0 + CW'(BARRY_ARM_W))
           && (w_cy > w_by0 + CW'(BARRY_PACK_H)) && (w_cy <= w_by1);
    w_in_barry = w_jet | w_head | w_torso;
  end

  game_state_t r_state, w_next_state;
  logic        w_hit_found, w_hit_flick;
  logic [HW-1:0] w_hit_sel;
  rgb_t        w_col;

  // Lowest-index obstacle wins; Barry is only drawn while playing.
  always_comb begin
    w_hit_found = 1'b0;
    w_hit_sel   = '0;
    w_hit_flick = 1'b0;
    for (int i = 0; i < N_OBS; i++) begin
      if (w_inside[i] && !w_hit_found) begin
        w_hit_found = 1'b1;
        w_hit_sel   = HW'(i);
        w_hit_flick = r_s1_flick[i];
      end
    end
    w_col = COL_BG_START;
    if (w_hit_found)              w_col = w_hit_flick ? COL_ORANGE : COL_YELLOW;
    else if (r_state == GS_PLAYING) begin
      if (w_fire)                 w_col = COL_ORANGE;
      else if (w_head)            w_col = COL_HEAD;
      else if (w_torso)           w_col = COL_TORSO;
      else if (w_jet)             w_col = COL_JETPACK;
      else                        w_col = COL_BG_PLAY;
    end else if (r_state == GS_OVER) w_col = COL_BG_OVER;
  end

  logic           r_s2_valid, r_s2_coll;
  logic [HW-1:0]  r_s2_hit;
  logic [C_W-1:0] r_r, r_g, r_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_coll  <= 1'b0;
      r_s2_hit   <= '0;
      r_r        <= '0;
      r_g        <= '0;
      r_b        <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_coll  <= r_s1_valid & w_hit_found & w_in_barry;
      if (r_s1_valid) begin
        r_s2_hit <= w_hit_sel;
        r_r      <= C_W'(w_col.r);
        r_g      <= C_W'(w_col.g);
        r_b      <= C_W'(w_col.b);
      end
    end
  end

  logic          w_capture;
  logic [HW-1:0] r_hit_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= GS_START;
      r_hit_idx <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) r_hit_idx <= r_s2_hit;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      GS_START:   if (on) w_next_state = GS_PLAYING;
      GS_PLAYING: if (r_s2_valid && r_s2_coll) begin
                    w_next_state = GS_OVER;
                    w_capture    = 1'b1;
                  end
      GS_OVER:    if (restart) w_next_state = GS_START;
      default:    w_next_state = GS_START;
    endcase
  end

  assign out_valid  = r_s2_valid;
  assign r          = r_r;
  assign g          = r_g;
  assign b          = r_b;
  assign game_state = r_state;
  assign game_over  = (r_state == GS_OVER);
  assign hit_idx    = r_hit_idx;

endmodule

// File: tb/tb_obstacle_compositor.sv
// Directed bench for obstacle_compositor: colour priority, clipping, collision
// timing, FSM transitions and asynchronous reset.
module tb_obstacle_compositor;

  localparam int N_OBS = 4;
  localparam int X_W   = 10;
  localparam int Y_W   = 9;
  localparam int C_W   = 8;
  localparam int HW    = 2;

  logic                 clk, reset, in_valid, on, restart;
  logic [X_W-1:0]       x, barry_x0, barry_x1;
  logic [Y_W-1:0]       y, barry_y0, barry_y1;
  logic [N_OBS-1:0]     obs_en, flick;
  logic [2*N_OBS-1:0]   obs_type, obs_pos;
  logic [N_OBS*X_W-1:0] obs_x;
  logic                 out_valid, game_over;
  logic [C_W-1:0]       r, g, b;
  logic [1:0]           game_state;
  logic [HW-1:0]        hit_idx;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int first_over;

  obstacle_compositor #(.N_OBS(N_OBS), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .x(x), .y(y),
    .barry_x0(barry_x0), .barry_x1(barry_x1), .barry_y0(barry_y0), .barry_y1(barry_y1),
    .on(on), .restart(restart), .obs_en(obs_en), .obs_type(obs_type), .obs_pos(obs_pos),
    .obs_x(obs_x), .flick(flick), .out_valid(out_valid), .r(r), .g(g), .b(b),
    .game_state(game_state), .game_over(game_over), .hit_idx(hit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_total++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic set_obs(input int i, input logic en, input logic [1:0] typ,
                         input logic [1:0] pos, input int ox, input logic fl);
    obs_en[i]            = en;
    obs_type[2*i +: 2]   = typ;
    obs_pos[2*i +: 2]    = pos;
    obs_x[X_W*i +: X_W]  = X_W'(ox);
    flick[i]             = fl;
  endtask

  // Sends one pixel and checks it two cycles later.
  task automatic pix(input string tag, input int px, input int py, input logic [23:0] exp_rgb);
    x = X_W'(px);
    y = Y_W'(py);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check({tag, "_ov"}, 32'(out_valid), 32'd1);
    check(tag, 32'({r, g, b}), 32'(exp_rgb));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; on = 1'b0; restart = 1'b0;
    x = '0; y = '0;
    barry_x0 = 10'd20; barry_x1 = 10'd50; barry_y0 = 9'd420; barry_y1 = 9'd479;
    obs_en = '0; flick = '0; obs_type = '0; obs_pos = '0; obs_x = '0;
    step(); step();
    check("rst_ov", 32'(out_valid), 0);
    check("rst_rgb", 32'({r, g, b}), 0);
    check("rst_state", 32'(game_state), 0);
    check("rst_over", 32'(game_over), 0);
    check("rst_hit", 32'(hit_idx), 0);
    reset = 1'b0;

    // Latency in START
    x = 10'd5; y = 9'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat1_ov", 32'(out_valid), 0);
    step();
    check("lat2_ov", 32'(out_valid), 1);
    check("start_bg", 32'({r, g, b}), 32'h00FF00);

    on = 1'b1; step(); on = 1'b0;
    check("start_to_play", 32'(game_state), 1);

    // Barry regions
    pix("play_bg", 100, 100, 24'hF0F0F0);
    pix("head", 40, 425, 24'hA4674A);
    pix("torso", 40, 450, 24'h0A0A80);
    pix("jetpack", 25, 440, 24'h141414);
    pix("torso_over_jet", 30, 440, 24'h0A0A80);
    pix("jet_bottom", 25, 465, 24'h141414);
    pix("fire_off", 25, 470, 24'hF0F0F0);
    on = 1'b1;
    pix("fire_on", 25, 470, 24'hFF8000);
    on = 1'b0;
    pix("torso_corner", 50, 479, 24'h0A0A80);
    pix("right_of_barry", 51, 479, 24'hF0F0F0);

    // Channel priority
    set_obs(1, 1'b1, 2'd0, 2'd1, 350, 1'b1);
    set_obs(3, 1'b1, 2'd0, 2'd1, 350, 1'b0);
    pix("prio_ch1", 300, 200, 24'hFF8000);
    set_obs(1, 1'b0, 2'd0, 2'd1, 350, 1'b1);
    pix("prio_ch3", 300, 200, 24'hFFFF00);
    set_obs(3, 1'b0, 2'd0, 2'd1, 350, 1'b0);

    // Triangles
    set_obs(2, 1'b1, 2'd3, 2'd0, 600, 1'b0);
    pix("rise_edge_in", 500, 79, 24'hFFFF00);
    pix("rise_edge_out", 500, 78, 24'hF0F0F0);
    pix("rise_corner", 579, 0, 24'hFFFF00);
    set_obs(2, 1'b1, 2'd2, 2'd0, 600, 1'b0);
    pix("fall_out", 500, 1, 24'hF0F0F0);
    pix("fall_diag", 510, 10, 24'hFFFF00);
    set_obs(2, 1'b0, 2'd2, 2'd0, 600, 1'b0);

    // Left-edge clipping, disabled lane, fully off-screen
    set_obs(0, 1'b1, 2'd0, 2'd0, 40, 1'b0);
    pix("clip_col0", 0, 80, 24'hFFFF00);
    pix("clip_ox1", 99, 80, 24'hFFFF00);
    pix("clip_past", 100, 80, 24'hF0F0F0);
    pix("clip_nowrap", 1000, 80, 24'hF0F0F0);
    set_obs(0, 1'b1, 2'd0, 2'd3, 40, 1'b0);
    pix("pos3_off", 50, 80, 24'hF0F0F0);
    set_obs(0, 1'b1, 2'd1, 2'd0, 20, 1'b0);
    pix("offscreen", 0, 50, 24'hF0F0F0);

    // Streamed collision: first overlap is (20,439), stream index 84
    set_obs(0, 1'b1, 2'd0, 2'd2, 100, 1'b0);
    first_over = -1;
    for (int s = 0; s < 140; s++) begin
      if (s < 128) begin
        in_valid = 1'b1;
        x = X_W'(s % 64);
        y = Y_W'(438 + s / 64);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (first_over < 0 && game_over) first_over = s + 1;
    end
    check("over_latency", 32'(first_over), 87);
    check("over_state", 32'(game_state), 2);
    check("hit_idx0", 32'(hit_idx), 0);
    pix("over_bg", 300, 300, 24'h0000FF);
    pix("over_no_barry", 40, 425, 24'h0000FF);
    pix("over_obs", 100, 450, 24'hFFFF00);

    on = 1'b1; step(); on = 1'b0; step();
    check("on_in_over", 32'(game_state), 2);
    restart = 1'b1; step(); restart = 1'b0;
    check("restart_state", 32'(game_state), 0);
    check("restart_over", 32'(game_over), 0);

    // No collision in START; obstacle still drawn over Barry's box
    pix("start_obs", 25, 440, 24'hFFFF00);
    pix("start_no_barry", 40, 425, 24'h00FF00);
    step();
    check("start_no_coll", 32'(game_state), 0);

    on = 1'b1; step(); on = 1'b0;
    check("replay1", 32'(game_state), 1);
    restart = 1'b1; step(); restart = 1'b0;
    check("restart_in_play", 32'(game_state), 1);

    // Collision and restart in the same cycle
    set_obs(0, 1'b0, 2'd0, 2'd2, 100, 1'b0);
    set_obs(2, 1'b1, 2'd0, 2'd2, 100, 1'b0);
    x = 10'd25; y = 9'd440; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("coll_pix", 32'({r, g, b}), 32'hFFFF00);
    restart = 1'b1; step(); restart = 1'b0;
    check("coll_vs_restart", 32'(game_state), 2);
    check("coll_over", 32'(game_over), 1);
    check("hit_idx2", 32'(hit_idx), 2);
    restart = 1'b1; step(); restart = 1'b0;
    check("restart2_state", 32'(game_state), 0);
    check("restart2_over", 32'(game_over), 0);

    // Asynchronous reset mid-frame
    on = 1'b1; step(); on = 1'b0;
    check("replay2", 32'(game_state), 1);
    x = 10'd100; y = 9'd100; in_valid = 1'b1;
    step(); step(); step();
    check("pre_rst_ov", 32'(out_valid), 1);
    check("pre_rst_rgb", 32'({r, g, b}), 32'hF0F0F0);
    #2 reset = 1'b1;
    #1;
    check("arst_ov", 32'(out_valid), 0);
    check("arst_rgb", 32'({r, g, b}), 0);
    check("arst_state", 32'(game_state), 0);
    check("arst_over", 32'(game_over), 0);
    check("arst_hit", 32'(hit_idx), 0);
    in_valid = 1'b0;
    step(); step();
    reset = 1'b0;
    x = 10'd5; y = 9'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("resume_lat1", 32'(out_valid), 0);
    step();
    check("resume_lat2", 32'(out_valid), 1);
    check("resume_rgb", 32'({r, g, b}), 32'h00FF00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/obstacle_compositor.md
# obstacle_compositor

Parametrised, pipelined pixel compositor and collision engine for N obstacles plus Barry. It sits between the VGA pixel counter and the colour DAC. For each valid pixel it evaluates every obstacle's shape from packaged geometry constants and resolves colour priority. It detects Barry/obstacle overlap and runs the start/playing/game-over state machine internally.

## Interface
- N_OBS, 4: number of obstacle channels (1..8)
- X_W, 10: x coordinate width
- Y_W, 9: y coordinate width
- C_W, 8: colour channel width
- clk  in  1: pixel clock
- reset  in  1: asynchronous, active-high
- in_valid  in  1: x/y is a visible pixel this cycle
- x  in  X_W: pixel column
- y  in  Y_W: pixel row
- barry_x0, barry_x1  in  X_W: Barry bounding box columns
- barry_y0, barry_y1  in  Y_W: Barry bounding box rows
- on  in  1: jetpack thrust; also the start request
- restart  in  1: single-cycle pulse, return from game over to start
- obs_en  in  N_OBS: channel i active
- obs_type  in  N_OBS×2: 0 flat, 1 tall, 2 falling triangle, 3 rising triangle
- obs_pos  in  N_OBS×2: 0 top, 1 middle, 2 bottom, 3 treated as disabled
- obs_x  in  N_OBS×X_W: obstacle anchor column
- flick  in  N_OBS: orange (1) / yellow (0) select
- out_valid  out  1: r/g/b valid, in_valid delayed 2
- r, g, b  out  C_W each: pixel colour
- game_state  out  2: 00 START, 01 PLAYING, 10 OVER
- game_over  out  1: high while OVER
- hit_idx  out  $clog2(N_OBS) (min 1): lowest colliding channel, captured on entry to OVER

## Operation
- Bounds per channel, computed at X_W+1 signed width:
  - ox0 = obs_x − 100 + DX0[type]; ox1 = obs_x − 100 + DX1[type].
  - oy0 = ROW[pos] + DY0[type]; oy1 = ROW[pos] + DY1[type]; ROW = {0, 140, 379}.
  - Negative ox0 clips to 0.
  - ox1 < 0 means the channel is off-screen and never inside.
- Inside tests, all bounds inclusive:
  - flat / tall: rectangle.
  - falling: rectangle and (y − oy0) ≤ (x − ox0), using the unclipped ox0.
  - rising: rectangle and y + (x − ox0) ≥ oy1, using the unclipped ox0.
- Barry regions:
  - jetpack: x0 ≤ x ≤ x0+10, y0+15 ≤ y ≤ y0+45.
  - head: x0+10 ≤ x ≤ x1, y0 ≤ y < y0+15.
  - torso: x0+10 ≤ x ≤ x1, y0+15 ≤ y ≤ y1.
  - fire: x0 ≤ x ≤ x0+10, y0+45 < y ≤ y1, only when on=1.
  - inside_barry = jetpack | head | torso; fire is not included.
- Colour priority, highest first:
  - lowest-index inside obstacle: flick ? FF,80,00 : FF,FF,00.
  - PLAYING only: fire FF,80,00; head A4,67,4A; torso 0A,0A,80; jetpack 14,14,14.
  - background: START 00,FF,00; PLAYING F0,F0,F0; OVER 00,00,FF.
- FSM:
  - START → PLAYING when on=1.
  - PLAYING → OVER on a collision: stage-2 valid pixel with inside_barry & any inside_obs. hit_idx is captured in the same cycle.
  - OVER → START on restart=1.
  - restart in START or PLAYING is ignored.
  - on in OVER is ignored.
  - A collision and restart in the same cycle resolve to OVER.

## Timing
- Stage 1 (registered): type/pos lookup, bounds, Barry box latched with x/y.
- Stage 2 (registered): inside tests, priority, colour; out_valid = in_valid delayed 2.
- game_state and game_over update the cycle after the colliding pixel reaches stage 2, i.e. 3 cycles after its in_valid.
- Pixels already in the pipe at the transition are still coloured with the state sampled at stage 2.
- in_valid=0 bubbles propagate: out_valid=0, r/g/b held, no collision evaluated.
- Reset, asynchronous at any time: r/g/b=0, out_valid=0, pipeline valids=0, game_state=START, game_over=0, hit_idx=0.

## Structure
- Package obstacle_pkg:
  - game_state_t enum.
  - OBS_DX0/DX1/DY0/DY1 constant arrays indexed by type.
  - ROW_Y array.
  - OBS_X_MARGIN = 100.
  - colour localparams.
- Sub-module obstacle_shape: one channel's bounds plus inside test, instantiated N_OBS times via generate.
- The FSM stays in the top level.

## Test plan
- Reset, then on=1 for 1 cycle → game_state=01 after 1 cycle; out_valid follows in_valid with 2-cycle latency.
- PLAYING, Barry box (20,50,420,479), obs0 flat bottom with obs_x placed so it overlaps rows 420+; scan the frame → game_over=1 three cycles after the first overlapping pixel, hit_idx=0, later pixels blue background.
- obs1 and obs3 overlapping at (300,200), flick1=1 → pixel FF,80,00 (channel 1 wins); obs_en[1]=0 → channel 3 colour.
- obs0 with obs_x=40 (ox0 negative) → columns 0..ox1 drawn, nothing wraps to the right edge; obs_pos=3 → never drawn.
- Collision and restart in the same cycle → OVER; a later restart → START and game_over=0.
- Assert reset mid-frame while out_valid=1 → all outputs zero immediately; resume scan → first out_valid 2 cycles after in_valid.
